spi_master_slave: RTL and testbench
===================================

# spi_master_slave

Full-duplex 8-bit SPI link that pairs a master and a slave on one synchronous clock domain. The master frames each transfer with active-low `ss` and shifts `data_in` out on `mosi`. In the same frame, the slave shifts `data_transfer` out on `miso`. After 8 bits, the master holds the slave's byte on `data_out` and the slave holds the master's byte on `slave_rx`. The block sits at the boundary between a byte-oriented controller and a serial peripheral link, and doubles as a loopback for link bring-up.

## Interface
- No parameters. Frame width is fixed at 8 bits, MSB first.
- One clock; reset is synchronous and active-high.
- `sclk` input 1: the single clock. All flops update on its rising edge.
- `rst` input 1: synchronous, active-high reset.
- `data_in` input 8: byte the master transmits. Sampled at frame start.
- `data_transfer` input 8: byte the slave transmits. Sampled at frame start.
- `data_out` output 8: byte the master received, registered.
- `slave_rx` output 8: byte the slave received, registered.
- `ss` output 1: slave select, active low.
- `mosi` output 1: master-to-slave serial data.
- `miso` output 1: slave-to-master serial data.
- `done` output 1: one-cycle pulse when `data_out` and `slave_rx` update.

## Operation
- Master FSM states: IDLE, LOAD, SHIFT, DONE.
- IDLE → LOAD unconditionally on the first non-reset cycle.
- LOAD:
  - Master latches `data_in` into its TX shift register; slave latches `data_transfer` into its TX shift register.
  - Drive `ss`=0, `mosi`=`data_in[7]`, `miso`=`data_transfer[7]`.
  - Bit counter = 0. Next state SHIFT.
- SHIFT, each cycle:
  - Master shifts the current `miso` into its RX register LSB; slave shifts the current `mosi` into its RX register LSB.
  - Both TX registers shift left and present the next bit.
  - Counter increments. After the 8th sample, go to DONE.
- DONE:
  - `ss`=1. Copy the master RX register to `data_out` and the slave RX register to `slave_rx`. Pulse `done`=1.
  - Next state LOAD, so frames repeat back-to-back with one `ss`-high gap cycle.
- The slave acts only while `ss`=0. With `ss`=1 it holds its shift state and drives `miso`=0.
- Changes on `data_in` or `data_transfer` mid-frame have no effect until the next LOAD.
- Arithmetic: counter is 3 bits plus a terminal flag, or 4 bits. No overflow past 8.

## Timing
- Reset values: `ss`=1, `mosi`=0, `miso`=0, `data_out`=0x00, `slave_rx`=0x00, `done`=0. FSM returns to IDLE, counter and all shift registers clear.
- Take cycle 0 as the first rising edge with `rst`=0.
  - Edge 0: FSM IDLE→LOAD.
  - Edge 1: `ss` falls and bit 7 appears on both lines.
  - Edges 2–9: bits sampled.
  - Edge 10: `ss` rises, `data_out`/`slave_rx` valid, `done`=1.
  - Edge 11: next frame starts (`ss` low).
- Frame period: 10 cycles, 9 with `ss` low. Latency from reset release to valid `data_out`: 11 edges.
- Reset mid-frame: on the next edge, all outputs return to reset values, with `data_out`/`slave_rx` cleared and no partial byte committed. The frame restarts from IDLE after release.
- `done` never asserts during or immediately out of reset.

## Structure
- Shared package `spi_pkg`: `FRAME_BITS`=8 and the state enum `spi_state_t` {IDLE, LOAD, SHIFT, DONE}.
- The top module holds the master FSM, counter, master shift registers and the `done` pulse.
- One sub-module, `spi_slave`, holds its TX/RX shift registers and responds to `ss`/`mosi`. It contains no FSM and is driven solely by `ss` framing.

## Test plan
- Basic exchange:
  - Stimulus: hold `rst`=1 for 25 cycles with `data_in`=0xEA and `data_transfer`=0xEE, then release.
  - `mosi` bit sequence: 1,1,1,0,1,0,1,0. `miso` bit sequence: 1,1,1,0,1,1,1,0.
  - At edge 10: `data_out`=0xEE, `slave_rx`=0xEA, `done`=1.
- Reset values: while `rst`=1, check `ss`=1, `mosi`=0, `miso`=0, `data_out`=0, `slave_rx`=0 and `done`=0 on every cycle.
- Back-to-back frames:
  - Change `data_in` to 0x5A and `data_transfer` to 0xC3 after the first `done`.
  - Second `done` comes exactly 10 cycles later, with `data_out`=0xC3 and `slave_rx`=0x5A.
  - `ss` is high for exactly one cycle between frames.
- Mid-frame input change: frame starts with `data_in`=0xFF, which changes to 0x00 at bit 3. `slave_rx`=0xFF for that frame.
- Reset mid-frame:
  - Assert `rst` at bit 4 of a 0xA5/0x3C exchange.
  - Next edge: outputs return to reset values and `data_out` stays 0x00.
  - After release, a full frame completes with `data_out`=0x3C.
- Extremes: exchange 0x00 against 0xFF, then 0xFF against 0x00. Both directions are received exactly.

Source files
------------

// File: rtl/spi_pkg.sv
// spi_pkg: frame width, counter width and master state encoding shared by the SPI link
package spi_pkg;
   localparam int FRAME_BITS = 8;
   localparam int CNT_W = $clog2(FRAME_BITS);
   typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} spi_state_t;
endpackage

// File: rtl/spi_slave.sv
// spi_slave: shift-register slave framed purely by the master's ss and its next value
module spi_slave
   import spi_pkg::*;
(
   input  logic                  sclk,
   input  logic                  rst,
   input  logic                  ss,
   input  logic                  ss_next,
   input  logic                  mosi,
   input  logic [FRAME_BITS-1:0] data_transfer,
   output logic                  miso,
   output logic [FRAME_BITS-1:0] slave_rx
);
   logic [FRAME_BITS-1:0] tx_q, tx_d, rx_q, rx_d, slave_rx_q, slave_rx_d;
   logic                  miso_q, miso_d;
   // ss falling loads the byte, ss held low shifts, ss rising commits the received byte
   always_comb begin
      tx_d       = tx_q;
      rx_d       = rx_q;
      slave_rx_d = slave_rx_q;
      miso_d     = 1'b0;
      if (ss && !ss_next) begin
         tx_d   = data_transfer;
         rx_d   = '0;
         miso_d = data_transfer[FRAME_BITS-1];
      end else if (!ss && !ss_next) begin
         rx_d   = {rx_q[FRAME_BITS-2:0], mosi};
         tx_d   = {tx_q[FRAME_BITS-2:0], 1'b0};
         miso_d = tx_q[FRAME_BITS-2];
      end else if (!ss && ss_next) begin
         slave_rx_d = rx_q;
      end
   end
   always_ff @(posedge sclk) begin
      if (rst) begin
         tx_q       <= '0;
         rx_q       <= '0;
         slave_rx_q <= '0;
         miso_q     <= 1'b0;
      end else begin
         tx_q       <= tx_d;
         rx_q       <= rx_d;
         slave_rx_q <= slave_rx_d;
         miso_q     <= miso_d;
      end
   end
   assign miso     = miso_q;
   assign slave_rx = slave_rx_q;
endmodule

// File: rtl/spi_master_slave.sv
// spi_master_slave: 8-bit full-duplex SPI master with an attached slave, frames repeat back-to-back
module spi_master_slave
   import spi_pkg::*;
(
   input  logic                  sclk,
   input  logic                  rst,
   input  logic [FRAME_BITS-1:0] data_in,
   input  logic [FRAME_BITS-1:0] data_transfer,
   output logic [FRAME_BITS-1:0] data_out,
   output logic [FRAME_BITS-1:0] slave_rx,
   output logic                  ss,
   output logic                  mosi,
   output logic                  miso,
   output logic                  done
);
   spi_state_t            state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [FRAME_BITS-1:0] tx_q, tx_d, rx_q, rx_d, data_out_q, data_out_d;
   logic                  ss_q, ss_d, mosi_q, mosi_d, done_q, done_d;
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      tx_d       = tx_q;
      rx_d       = rx_q;
      ss_d       = ss_q;
      mosi_d     = mosi_q;
      data_out_d = data_out_q;
      done_d     = 1'b0;
      case (state_q)
         IDLE: state_d = LOAD;
         LOAD: begin
            tx_d    = data_in;
            rx_d    = '0;
            ss_d    = 1'b0;
            mosi_d  = data_in[FRAME_BITS-1];
            cnt_d   = '0;
            state_d = SHIFT;
         end
         SHIFT: begin
            rx_d    = {rx_q[FRAME_BITS-2:0], miso};
            tx_d    = {tx_q[FRAME_BITS-2:0], 1'b0};
            mosi_d  = tx_q[FRAME_BITS-2];
            cnt_d   = cnt_q + 1'b1;
            state_d = (cnt_q == CNT_W'(FRAME_BITS - 1)) ? DONE : SHIFT;
         end
         DONE: begin
            ss_d       = 1'b1;
            mosi_d     = 1'b0;
            data_out_d = rx_q;
            done_d     = 1'b1;
            state_d    = LOAD;
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge sclk) begin
      if (rst) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         tx_q       <= '0;
         rx_q       <= '0;
         ss_q       <= 1'b1;
         mosi_q     <= 1'b0;
         data_out_q <= '0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         tx_q       <= tx_d;
         rx_q       <= rx_d;
         ss_q       <= ss_d;
         mosi_q     <= mosi_d;
         data_out_q <= data_out_d;
         done_q     <= done_d;
      end
   end
   spi_slave u_slave (
      .sclk          (sclk),
      .rst           (rst),
      .ss            (ss_q),
      .ss_next       (ss_d),
      .mosi          (mosi_q),
      .data_transfer (data_transfer),
      .miso          (miso),
      .slave_rx      (slave_rx)
   );
   assign data_out = data_out_q;
   assign ss       = ss_q;
   assign mosi     = mosi_q;
   assign done     = done_q;
endmodule

// File: tb/tb_spi_master_slave.sv
// tb_spi_master_slave: directed frames with hand-computed bit streams and received bytes
module tb_spi_master_slave;
   logic       sclk = 1'b0, rst = 1'b1;
   logic [7:0] data_in, data_transfer, data_out, slave_rx;
   logic       ss, mosi, miso, done;
   int         errors = 0, checks = 0;
   logic [7:0] prev_out = 8'h00, prev_rx = 8'h00;
   spi_master_slave dut (
      .sclk          (sclk),
      .rst           (rst),
      .data_in       (data_in),
      .data_transfer (data_transfer),
      .data_out      (data_out),
      .slave_rx      (slave_rx),
      .ss            (ss),
      .mosi          (mosi),
      .miso          (miso),
      .done          (done)
   );
   always #5 sclk = ~sclk;
   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask
   task automatic step();
      @(posedge sclk);
      @(negedge sclk);
   endtask
   task automatic check_reset_vals();
      check("rst ss", ss, 1);
      check("rst mosi", mosi, 0);
      check("rst miso", miso, 0);
      check("rst data_out", data_out, 8'h00);
      check("rst slave_rx", slave_rx, 8'h00);
      check("rst done", done, 0);
   endtask
   // Runs edges 1..10 of a frame whose LOAD happens on the next edge; chg flips data_in mid-frame
   task automatic frame(input logic [7:0] din, input logic [7:0] dtr, input int chg);
      data_in = din;
      data_transfer = dtr;
      for (int e = 1; e <= 10; e++) begin
         step();
         if (e == chg) data_in = ~din;
         if (e <= 9) begin
            check("frame ss", ss, 0);
            check("frame done", done, 0);
            check("hold data_out", data_out, prev_out);
            check("hold slave_rx", slave_rx, prev_rx);
            if (e <= 8) begin
               check("mosi bit", mosi, din[8-e]);
               check("miso bit", miso, dtr[8-e]);
            end
         end else begin
            check("end ss", ss, 1);
            check("end done", done, 1);
            check("data_out", data_out, dtr);
            check("slave_rx", slave_rx, din);
         end
      end
      prev_out = dtr;
      prev_rx = din;
   endtask
   task automatic after_release();
      @(negedge sclk);
      rst = 1'b0;
      step();
      check("edge0 ss", ss, 1);
      check("edge0 done", done, 0);
   endtask
   initial begin
      data_in = 8'hEA;
      data_transfer = 8'hEE;
      for (int i = 0; i < 25; i++) begin
         step();
         check_reset_vals();
      end
      after_release();
      frame(8'hEA, 8'hEE, 0);
      frame(8'h5A, 8'hC3, 0);
      frame(8'hFF, 8'h81, 4);
      data_in = 8'hA5;
      data_transfer = 8'h3C;
      for (int i = 0; i < 5; i++) step();
      rst = 1'b1;
      step();
      check_reset_vals();
      step();
      check_reset_vals();
      prev_out = 8'h00;
      prev_rx = 8'h00;
      after_release();
      frame(8'hA5, 8'h3C, 0);
      frame(8'h00, 8'hFF, 0);
      frame(8'hFF, 8'h00, 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
